// File: rtl/wb_write_port.sv
// rtl/wb_write_port.sv - writeback-side driver of the register file write port
//
// Merges in-order MEM/WB pipeline results with mult/div results buffered in a
// small circular FIFO. The pipeline always has priority. The selected write is
// registered and exported both to the register file and as a forwarding source.
//
// Optional feature macro: WB_BYPASS_EN. When defined, an md result offered while
// the pipeline slot is idle and the FIFO is empty is written directly with
// 1-cycle latency instead of being buffered.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_valid, mem_reg_write   retiring pipeline slot / writes a GPR
//   mem_mem_to_reg             select load data (1) or ALU result (0)
//   mem_dest, mem_alu_result, mem_load_data  pipeline write address and data
//   md_valid, md_dest, md_data mult/div result offer
//   md_ready                   FIFO can accept (transfer = md_valid && md_ready)
//   reg_write_en, read_dest, write_data   register file write port
//   fwd_valid, fwd_dest, fwd_data         forwarding copy of the write port

module wb_write_port #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic          mem_mem_to_reg,
  input  logic [4:0]    mem_dest,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_load_data,
  input  logic          md_valid,
  input  logic [4:0]    md_dest,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  output logic          reg_write_en,
  output logic [4:0]    read_dest,
  output logic [DW-1:0] write_data,
  output logic          fwd_valid,
  output logic [4:0]    fwd_dest,
  output logic [DW-1:0] fwd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       fifo_dest [DEPTH];
  logic [DW-1:0]    fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             pw;
  logic [DW-1:0]    pipe_data;
  logic             md_fire;
  logic             head_valid;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] kill_mask;

  logic             en_nxt;
  logic [4:0]       dest_nxt;
  logic [DW-1:0]    data_nxt;

  assign pw        = mem_valid && mem_reg_write && (mem_dest != 5'd0);
  assign pipe_data = mem_mem_to_reg ? mem_load_data : mem_alu_result;

  // Ready comes from the registered count only; a pop this cycle does not
  // open a slot until the next cycle.
  assign md_ready   = !reset && (count < CW'(DEPTH));
  assign md_fire    = md_valid && md_ready;
  assign head_valid = (count != '0) && fifo_vld[rd_ptr];

`ifdef WB_BYPASS_EN
  assign bypass = !pw && (count == '0) && md_fire && (md_dest != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Results to $0, results overtaken by a same-cycle pipeline write to the
  // same register, and bypassed results are accepted but never stored.
  assign push = md_fire && (md_dest != 5'd0) && !(pw && (md_dest == mem_dest)) && !bypass;

  // Any idle slot drains the head, including heads whose entry was killed.
  assign pop = !pw && (count != '0);

  // A pipeline write is younger than everything buffered, so buffered results
  // to the same register become stale and must never reach the register file.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_mask[i] = pw && (fifo_dest[i] == mem_dest);
    end
  end

  always_comb begin
    en_nxt   = 1'b0;
    dest_nxt = read_dest;
    data_nxt = write_data;
    if (pw) begin
      en_nxt   = 1'b1;
      dest_nxt = mem_dest;
      data_nxt = pipe_data;
    end else if (bypass) begin
      en_nxt   = 1'b1;
      dest_nxt = md_dest;
      data_nxt = md_data;
    end else if (head_valid) begin
      en_nxt   = 1'b1;
      dest_nxt = fifo_dest[rd_ptr];
      data_nxt = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_en <= 1'b0;
      read_dest    <= 5'd0;
      write_data   <= '0;
      fifo_vld     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      reg_write_en <= en_nxt;
      read_dest    <= dest_nxt;
      write_data   <= data_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == AW'(i))) begin
          fifo_vld[i] <= 1'b1;
        end else if (kill_mask[i] || (pop && (rd_ptr == AW'(i)))) begin
          fifo_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage needs no reset; entries are qualified by fifo_vld/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= md_dest;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  assign fwd_valid = reg_write_en;
  assign fwd_dest  = read_dest;
  assign fwd_data  = write_data;

endmodule

// File: tb/tb_wb_write_port.sv
// tb/tb_wb_write_port.sv - scoreboard testbench for wb_write_port
module tb_wb_write_port;

  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid;
  logic          mem_reg_write;
  logic          mem_mem_to_reg;
  logic [4:0]    mem_dest;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_load_data;
  logic          md_valid;
  logic [4:0]    md_dest;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic          reg_write_en;
  logic [4:0]    read_dest;
  logic [DW-1:0] write_data;
  logic          fwd_valid;
  logic [4:0]    fwd_dest;
  logic [DW-1:0] fwd_data;

  wb_write_port #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .md_valid(md_valid), .md_dest(md_dest), .md_data(md_data), .md_ready(md_ready),
    .reg_write_en(reg_write_en), .read_dest(read_dest), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    dest;
    logic [DW-1:0] data;
    bit            valid;
  } ent_t;

  typedef struct {
    int            cyc;
    bit            en;
    logic [4:0]    dest;
    logic [DW-1:0] data;
  } exp_t;

  ent_t mq[$];          // reference FIFO contents, oldest first
  exp_t sq[$];          // expected register-file port state per edge
  logic [4:0]    last_dest = 5'd0;
  logic [DW-1:0] last_data = '0;

  int edge_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;
  exp_t me;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, then predict what the next edge must produce.
  task automatic step(input bit rst, input bit mv, input bit mrw, input bit m2r,
                      input logic [4:0] mdst, input logic [DW-1:0] alu, input logic [DW-1:0] ld,
                      input bit mdv, input logic [4:0] mddst, input logic [DW-1:0] mddat);
    bit pw, ready, fire, byp;
    exp_t e;
    ent_t h;
    @(negedge clk);
    reset = rst; mem_valid = mv; mem_reg_write = mrw; mem_mem_to_reg = m2r;
    mem_dest = mdst; mem_alu_result = alu; mem_load_data = ld;
    md_valid = mdv; md_dest = mddst; md_data = mddat;
    #1;
    ready = !rst && (mq.size() < DEPTH);
    chk("md_ready", md_ready, ready);
    fire = mdv && ready;
    pw = mv && mrw && (mdst != 0);
    e.cyc = edge_cnt + 1;
    e.en = 0;
    if (rst) begin
      mq.delete();
      last_dest = 0;
      last_data = 0;
    end else begin
      byp = 0;
`ifdef WB_BYPASS_EN
      byp = !pw && (mq.size() == 0) && fire && (mddst != 0);
`endif
      if (pw) begin
        e.en = 1; last_dest = mdst; last_data = m2r ? ld : alu;
        foreach (mq[i]) if (mq[i].dest == mdst) mq[i].valid = 0;
      end else if (byp) begin
        e.en = 1; last_dest = mddst; last_data = mddat;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.valid) begin
          e.en = 1; last_dest = h.dest; last_data = h.data;
        end
      end
      if (fire && mddst != 0 && !(pw && mddst == mdst) && !byp) begin
        h.dest = mddst; h.data = mddat; h.valid = 1;
        mq.push_back(h);
      end
    end
    e.dest = last_dest;
    e.data = last_data;
    sq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pipe(input logic [4:0] d, input logic [DW-1:0] v, input bit mdv,
                      input logic [4:0] mdd, input logic [DW-1:0] mdx);
    step(0, 1, 1, 0, d, v, 32'hdead_beef, mdv, mdd, mdx);
  endtask

  always @(posedge clk) begin
    #1;
    if (sq.size() > 0) begin
      me = sq.pop_front();
      chk("edge_index", 64'(edge_cnt), 64'(me.cyc));
      chk("reg_write_en", reg_write_en, me.en);
      chk("read_dest", read_dest, me.dest);
      chk("write_data", write_data, me.data);
      chk("fwd_valid", fwd_valid, me.en);
      chk("fwd_dest", fwd_dest, me.dest);
      chk("fwd_data", fwd_data, me.data);
    end
  end

  initial begin
    reset = 1; mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0; mem_dest = 0;
    mem_alu_result = 0; mem_load_data = 0; md_valid = 0; md_dest = 0; md_data = 0;

    // reset with an md offer present, then release
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77);
    idle(1);

    // back-to-back pipeline writes, then a $0 write
    step(0, 1, 1, 0, 5, 25, 0, 0, 0, 0);
    step(0, 1, 1, 1, 8, 0, 58, 0, 0, 0);
    step(0, 1, 1, 0, 0, 99, 0, 0, 0, 0);
    idle(2);

    // priority: md buffered, pipeline wins two cycles, then drain
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h1234);
    pipe(3, 7, 0, 0, 0);
    pipe(3, 7, 0, 0, 0);
    idle(3);

    // fill the FIFO under continuous pipeline writes; third offer stalls
    pipe(1, 100, 1, 10, 1);
    pipe(2, 200, 1, 11, 2);
    pipe(6, 300, 1, 13, 3);
    idle(4);

    // kill of a buffered entry, then a same-cycle kill
    pipe(1, 5, 1, 12, 32'hAA);
    pipe(12, 32'hBB, 0, 0, 0);
    idle(3);
    pipe(12, 32'hDD, 1, 12, 32'hCC);
    idle(2);

    // md to $0 is swallowed; md alone into an empty FIFO (latency depends on bypass)
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 44);
    idle(3);

    // randomized traffic with a narrow register range to provoke kills
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom, $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom);
    end
    idle(4);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Writeback-side driver of the register file write port. It produces reg_write_en, read_dest and write_data, which connect to the register file's same-named inputs.
- It merges two sources:
  - the in-order MEM/WB pipeline result;
  - results from the multi-cycle mult/div unit, buffered in a small FIFO.
- It registers the selected write and exports it as a forwarding source for the decode/execute stages.

Parameters:
- DEPTH, 2, number of entries in the mult/div result FIFO (power of two, ≥2).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  pipeline slot holds a retiring instruction
- mem_reg_write  in  1  retiring instruction writes a GPR
- mem_mem_to_reg  in  1  1: write mem_load_data; 0: write mem_alu_result
- mem_dest  in  5  pipeline destination register
- mem_alu_result  in  DW  ALU result
- mem_load_data  in  DW  aligned load data
- md_valid  in  1  mult/div result offered
- md_dest  in  5  mult/div destination register
- md_data  in  DW  mult/div result
- md_ready  out  1  FIFO can accept; a transfer occurs when md_valid && md_ready
- reg_write_en  out  1  register file write enable
- read_dest  out  5  register file write address
- write_data  out  DW  register file write data
- fwd_valid  out  1  equals reg_write_en (forwarding source valid)
- fwd_dest  out  5  equals read_dest
- fwd_data  out  DW  equals write_data

Behaviour:
- **Reset.** On a clock edge with reset=1:
  - reg_write_en=0, read_dest=0, write_data=0;
  - FIFO emptied (count=0, pointers=0, all entry valid bits cleared);
  - md_ready forced 0 while reset is high.
  - Reset mid-drain discards all buffered entries; no write is issued.
- **Pipeline write request.** pw = mem_valid && mem_reg_write && (mem_dest != 0).
  - Pipeline data = mem_mem_to_reg ? mem_load_data : mem_alu_result.
- **Priority.** The pipeline always wins.
  - If pw: next registered output = {1, mem_dest, pipeline data}.
  - Else if the FIFO head is valid: the head is popped and output = {1, head dest, head data}.
  - Else output = {0, previous read_dest, previous write_data}; address and data hold, enable drops.
- **Latency.**
  - Pipeline input sampled at edge N → reg_write_en high for the cycle after edge N (1 cycle).
  - md transfer at edge N → earliest write visible after edge N+1 (2 cycles).
- **$0 rule.** Never write register 0.
  - Pipeline writes to $0 are ignored, and that slot counts as idle for draining.
  - md transfers with md_dest=0 are accepted and discarded (no entry allocated).
- **FIFO.**
  - Circular buffer with wrap-around pointers mod DEPTH.
  - count is 0..DEPTH; md_ready = (count < DEPTH), computed from registered count only; a same-cycle pop does not raise ready.
  - Push and pop in the same cycle: count unchanged.
- **Ordering / kill.** A pipeline write is younger than any buffered or same-cycle mult/div result.
  - When pw, every valid FIFO entry with dest == mem_dest has its valid bit cleared.
  - A killed entry is still popped in order but produces no write; that drain slot is wasted.
  - An md transfer in the same cycle with md_dest == mem_dest is accepted and discarded.
- **Head validity.** The FIFO head counts as valid only if count > 0 and its entry valid bit is 1. A head with valid bit 0 is popped silently when the slot is idle.
- **Starvation.** With continuous pw the FIFO does not drain. The FIFO holding DEPTH entries drops md_ready to 0, and the mult/div unit stalls (legal).

Optional Feature:
- WB_BYPASS_EN defined: when the pipeline slot is idle, the FIFO is empty and md_valid=1 (md_dest≠0), the md result bypasses the FIFO and is written with 1-cycle latency.
  - This is still reported as a transfer (md_ready=1).
  - A bypassed result is never also pushed.
- Not defined: all md results go through the FIFO, with 2-cycle minimum latency.

Test Plan:
- Reset held 2 cycles with md_valid=1 → md_ready=0, reg_write_en=0, read_dest=0, write_data=0; release → md_ready=1.
- Pipeline writes: dest=5, alu=25, then dest=8, mem_to_reg=1, load=58 on back-to-back edges → writes (5,25), (8,58) one cycle later each; dest=0 with alu=99 → no write.
- Priority: md (9,0x1234) pushed, pipeline (3,7) issued the following 2 cycles, then idle → writes (3,7), (3,7), then (9,0x1234).
- Full: DEPTH=2, md pushes (10,1), (11,2) under continuous pipeline writes → md_ready=0 on the 3rd offer. Pipeline then idle → drains 10 then 11, and md_ready returns to 1 after the first pop.
- Kill: FIFO holds (12,0xAA); pipeline writes (12,0xBB) → write (12,0xBB), and the drain issues no write for reg 12. md (12,0xCC) in the same cycle as pipeline (12,0xDD) → only 0xDD written.
- WB_BYPASS_EN: idle pipeline, empty FIFO, md (4,44) at edge N → write (4,44) after edge N. Without the macro, after edge N+1.
